poly_voice_ctrl: RTL and testbench

- Parametrised successor to the single-note UART-to-DDS control path. Parses a MIDI-style byte stream from uart_rx into note-on/note-off events.
- Allocates each event to one of NUM_VOICES voice slots. Drives per-voice note, velocity, gate and change strobe to a bank of dds instances, plus a per-voice LED bitmap.
- Sits between uart_rx and the dds/mixer bank, in the clk (24.576 MHz PLL) domain.

---
 rtl/poly_voice_ctrl_if.sv | 13 +
 rtl/poly_voice_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_poly_voice_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_voice_ctrl_if.sv
// Byte-stream handshake between uart_rx and poly_voice_ctrl.
//   rx_valid : byte available (held by the source until accepted)
//   rx_byte  : received byte
//   rx_ready : sink accepts the byte on a cycle with rx_valid && rx_ready
// master = uart_rx side, slave = poly_voice_ctrl side.
interface poly_voice_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_ready;

  modport master (output rx_valid, output rx_byte, input rx_ready);
  modport slave  (input rx_valid, input rx_byte, output rx_ready);
endinterface

// File: rtl/poly_voice_ctrl.sv
// poly_voice_ctrl: parses a MIDI-style note-on/note-off byte stream and
// allocates events to NUM_VOICES voice slots driving a dds bank.
// Ports:
//   clk, rst_n    : system clock, asynchronous active-low reset
//   rx            : byte handshake from uart_rx (slave modport)
//   voice_note    : per-voice note, voice i at [i*NOTE_WDTH +: NOTE_WDTH]
//   voice_vel     : per-voice velocity, packed the same way
//   voice_gate    : per-voice active flag
//   voice_change  : one-cycle strobe, voice note/vel/gate updated this cycle
//   led           : voice_gate delayed one cycle
//   err_count     : saturating protocol error count
// NOTE_WDTH and VEL_WDTH must not exceed 7 (MIDI data bytes carry 7 bits).
module poly_voice_ctrl #(
  parameter int unsigned NUM_VOICES     = 4,
  parameter int unsigned NOTE_WDTH      = 7,
  parameter int unsigned VEL_WDTH       = 7,
  parameter int unsigned TIMEOUT_CYCLES = 24576
) (
  input  logic                            clk,
  input  logic                            rst_n,
  poly_voice_ctrl_if.slave                rx,
  output logic [NUM_VOICES*NOTE_WDTH-1:0] voice_note,
  output logic [NUM_VOICES*VEL_WDTH-1:0]  voice_vel,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [NUM_VOICES-1:0]           voice_change,
  output logic [NUM_VOICES-1:0]           led,
  output logic [7:0]                      err_count
);

  localparam int unsigned PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_D1, S_D2, S_ALLOC} state_t;

  state_t                          state_q, state_d;
  logic                            is_on_q, is_on_d;
  logic [NOTE_WDTH-1:0]            note_q, note_d;
  logic [VEL_WDTH-1:0]             vel_q, vel_d;
  logic [TMO_W-1:0]                tmo_q, tmo_d;
  logic [7:0]                      err_q, err_d;
  logic [PTR_W-1:0]                steal_q, steal_d;
  logic [NUM_VOICES*NOTE_WDTH-1:0] vnote_q, vnote_d;
  logic [NUM_VOICES*VEL_WDTH-1:0]  vvel_q, vvel_d;
  logic [NUM_VOICES-1:0]           gate_q, gate_d;
  logic [NUM_VOICES-1:0]           change_q, change_d;
  logic [NUM_VOICES-1:0]           led_q;

  logic                            ready;
  logic                            accept;
  logic                            err_inc;
  logic                            hit, free;
  logic [NUM_VOICES-1:0]           hit_oh, free_oh, steal_oh, sel_oh;

  assign ready       = (state_q != S_ALLOC);
  assign rx.rx_ready = ready;
  assign accept      = rx.rx_valid && ready;

  assign voice_note   = vnote_q;
  assign voice_vel    = vvel_q;
  assign voice_gate   = gate_q;
  assign voice_change = change_q;
  assign led          = led_q;
  assign err_count    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_on_q  <= 1'b0;
      note_q   <= '0;
      vel_q    <= '0;
      tmo_q    <= '0;
      err_q    <= '0;
      steal_q  <= '0;
      vnote_q  <= '0;
      vvel_q   <= '0;
      gate_q   <= '0;
      change_q <= '0;
      led_q    <= '0;
    end else begin
      is_on_q  <= is_on_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      steal_q  <= steal_d;
      vnote_q  <= vnote_d;
      vvel_q   <= vvel_d;
      gate_q   <= gate_d;
      change_q <= change_d;
      led_q    <= gate_q;
    end
  end

  // Voice selection candidates for a note-on, all one-hot.
  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_oh   = '0;
    free_oh  = '0;
    steal_oh = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!hit && gate_q[i] && (vnote_q[i*NOTE_WDTH +: NOTE_WDTH] == note_q)) begin
        hit       = 1'b1;
        hit_oh[i] = 1'b1;
      end
      if (!free && !gate_q[i]) begin
        free       = 1'b1;
        free_oh[i] = 1'b1;
      end
      if (steal_q == PTR_W'(i)) begin
        steal_oh[i] = 1'b1;
      end
    end
    if (hit) begin
      sel_oh = hit_oh;
    end else if (free) begin
      sel_oh = free_oh;
    end else begin
      sel_oh = steal_oh;
    end
  end

  always_comb begin
    state_d  = state_q;
    is_on_d  = is_on_q;
    note_d   = note_q;
    vel_d    = vel_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    steal_d  = steal_q;
    vnote_d  = vnote_q;
    vvel_d   = vvel_q;
    gate_d   = gate_q;
    change_d = '0;
    err_inc  = 1'b0;

    if (accept) begin
      tmo_d = '0;
      if (rx.rx_byte[7]) begin
        // A status byte in D2 abandons a half-received message.
        if (state_q == S_D2) begin
          err_inc = 1'b1;
        end
        if (rx.rx_byte[7:5] == 3'b100) begin
          is_on_d = rx.rx_byte[4];
          state_d = S_D1;
        end else begin
          state_d = S_IDLE;
          if (rx.rx_byte == 8'hFF) begin
            change_d = gate_q;
            gate_d   = '0;
          end
        end
      end else begin
        case (state_q)
          S_IDLE: err_inc = 1'b1;
          S_D1: begin
            note_d  = rx.rx_byte[NOTE_WDTH-1:0];
            state_d = S_D2;
          end
          S_D2: begin
            vel_d   = rx.rx_byte[VEL_WDTH-1:0];
            state_d = S_ALLOC;
          end
          default: ;
        endcase
      end
    end else if (state_q == S_D2) begin
      // Accepted byte takes priority over the timeout by branch order.
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        err_inc = 1'b1;
        tmo_d   = '0;
        state_d = S_D1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (state_q == S_ALLOC) begin
      state_d = S_D1;
      if (is_on_q && (vel_q != '0)) begin
        if (!hit && !free) begin
          steal_d = (steal_q == PTR_W'(NUM_VOICES - 1)) ? '0 : steal_q + 1'b1;
        end
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
          if (sel_oh[i]) begin
            vnote_d[i*NOTE_WDTH +: NOTE_WDTH] = note_q;
            vvel_d[i*VEL_WDTH +: VEL_WDTH]    = vel_q;
            gate_d[i]                         = 1'b1;
            change_d[i]                       = 1'b1;
          end
        end
      end else begin
        // Note-off (or note-on with zero velocity): release every match.
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
          if (gate_q[i] && (vnote_q[i*NOTE_WDTH +: NOTE_WDTH] == note_q)) begin
            gate_d[i]   = 1'b0;
            change_d[i] = 1'b1;
          end
        end
      end
    end

    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_poly_voice_ctrl.sv
// Directed bench for poly_voice_ctrl (4 voices, short timeout).
module tb_poly_voice_ctrl;

  localparam int unsigned NV  = 4;
  localparam int unsigned TMO = 100;

  logic            clk;
  logic            rst_n;
  logic [NV*7-1:0] voice_note;
  logic [NV*7-1:0] voice_vel;
  logic [NV-1:0]   voice_gate;
  logic [NV-1:0]   voice_change;
  logic [NV-1:0]   led;
  logic [7:0]      err_count;

  int n_checks = 0;
  int n_errors = 0;

  poly_voice_ctrl_if rx_if ();

  poly_voice_ctrl #(
    .NUM_VOICES    (NV),
    .NOTE_WDTH     (7),
    .VEL_WDTH      (7),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx_if.slave),
    .voice_note  (voice_note),
    .voice_vel   (voice_vel),
    .voice_gate  (voice_gate),
    .voice_change(voice_change),
    .led         (led),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns 1 ns after the clock edge on which the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_if.rx_valid = 1'b1;
    rx_if.rx_byte  = b;
    while (!rx_if.rx_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!rx_if.rx_ready) check("rx_ready_wait", 32'(rx_if.rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  // Moves to 1 ns after the edge that registers the event (end of ALLOC).
  task automatic to_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rx_if.rx_valid = 1'b0;
    rx_if.rx_byte  = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Voices 0..3 = 3C,40,43,48 with vel 64,50,20,10; steal pointer at 0.
  task automatic load4();
    send3(8'h90, 8'h3C, 8'h64);
    send_byte(8'h40); send_byte(8'h50);
    send_byte(8'h43); send_byte(8'h20);
    send_byte(8'h48); send_byte(8'h10);
    to_update();
  endtask

  initial begin
    rst_n          = 1'b0;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_byte  = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_note",   32'(voice_note),   32'h0);
    check("rst_vel",    32'(voice_vel),    32'h0);
    check("rst_gate",   32'(voice_gate),   32'h0);
    check("rst_change", 32'(voice_change), 32'h0);
    check("rst_led",    32'(led),          32'h0);
    check("rst_err",    32'(err_count),    32'h0);
    check("rst_ready",  32'(rx_if.rx_ready), 32'h1);

    // First note-on, latency and ALLOC stall
    send3(8'h90, 8'h3C, 8'h64);
    check("alloc_ready", 32'(rx_if.rx_ready), 32'h0);
    check("pre_change",  32'(voice_change),   32'h0);
    to_update();
    check("n1_note",   32'(voice_note),   32'h3C);
    check("n1_vel",    32'(voice_vel),    32'h64);
    check("n1_gate",   32'(voice_gate),   32'h1);
    check("n1_change", 32'(voice_change), 32'h1);
    check("n1_led",    32'(led),          32'h0);
    to_update();
    check("n1_change_off", 32'(voice_change), 32'h0);
    check("n1_led_on",     32'(led),          32'h1);

    // Running status fills the remaining voices
    send_byte(8'h40); send_byte(8'h50);
    send_byte(8'h43); send_byte(8'h20);
    send_byte(8'h48); send_byte(8'h10);
    to_update();
    check("rs_gate", 32'(voice_gate), 32'hF);
    check("rs_note", 32'(voice_note), 32'({7'h48, 7'h43, 7'h40, 7'h3C}));
    check("rs_vel",  32'(voice_vel),  32'({7'h10, 7'h20, 7'h50, 7'h64}));

    // Stealing: voice 0 then voice 1
    send_byte(8'h4A); send_byte(8'h7F);
    to_update();
    check("steal0_change", 32'(voice_change), 32'h1);
    check("steal0_note",   32'(voice_note), 32'({7'h48, 7'h43, 7'h40, 7'h4A}));
    check("steal0_vel",    32'(voice_vel),  32'({7'h10, 7'h20, 7'h50, 7'h7F}));
    send_byte(8'h4B); send_byte(8'h01);
    to_update();
    check("steal1_change", 32'(voice_change), 32'h2);
    check("steal1_note",   32'(voice_note), 32'({7'h48, 7'h43, 7'h4B, 7'h4A}));

    // Note-off, vel=0 note-on, unmatched note-off
    do_reset();
    load4();
    send3(8'h80, 8'h40, 8'h00);
    to_update();
    check("off_gate",   32'(voice_gate),   32'hD);
    check("off_change", 32'(voice_change), 32'h2);
    check("off_note",   32'(voice_note), 32'({7'h48, 7'h43, 7'h40, 7'h3C}));
    send3(8'h90, 8'h3C, 8'h00);
    to_update();
    check("v0off_gate",   32'(voice_gate),   32'hC);
    check("v0off_change", 32'(voice_change), 32'h1);
    send3(8'h80, 8'h77, 8'h00);
    to_update();
    check("nomatch_gate",   32'(voice_gate),   32'hC);
    check("nomatch_change", 32'(voice_change), 32'h0);
    check("nomatch_err",    32'(err_count),    32'h0);

    // Retrigger leaves the steal pointer alone
    do_reset();
    load4();
    send3(8'h90, 8'h3C, 8'h22);
    to_update();
    check("retrig_change", 32'(voice_change), 32'h1);
    check("retrig_vel",    32'(voice_vel), 32'({7'h10, 7'h20, 7'h50, 7'h22}));
    check("retrig_gate",   32'(voice_gate), 32'hF);
    send3(8'h90, 8'h55, 8'h11);
    to_update();
    check("retrig_steal_change", 32'(voice_change), 32'h1);
    check("retrig_steal_note",   32'(voice_note), 32'({7'h48, 7'h43, 7'h40, 7'h55}));

    // Protocol errors and timeout
    do_reset();
    send_byte(8'h3C);
    check("err_data_idle", 32'(err_count), 32'd1);
    send_byte(8'h90);
    send_byte(8'h3C);
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("tmo_before", 32'(err_count), 32'd1);
    @(posedge clk);
    #1;
    check("tmo_at", 32'(err_count), 32'd2);
    send_byte(8'h3C); send_byte(8'h10);
    to_update();
    check("tmo_resume_gate", 32'(voice_gate), 32'h1);
    check("tmo_resume_note", 32'(voice_note), 32'h3C);
    check("tmo_resume_vel",  32'(voice_vel),  32'h10);
    send3(8'h90, 8'h40, 8'h90);
    check("err_status_d2", 32'(err_count), 32'd3);
    send_byte(8'h41); send_byte(8'h05);
    to_update();
    check("d2_restart_gate", 32'(voice_gate), 32'h3);
    send_byte(8'h80);
    check("d1_status_noerr", 32'(err_count), 32'd3);
    send_byte(8'h41); send_byte(8'h00);
    to_update();
    check("d1_off_gate",   32'(voice_gate),   32'h1);
    check("d1_off_change", 32'(voice_change), 32'h2);
    send_byte(8'hF8);
    check("other_status_noerr", 32'(err_count), 32'd3);
    send_byte(8'h30);
    check("other_status_clears_rs", 32'(err_count), 32'd4);

    // err_count saturation
    do_reset();
    for (int i = 0; i < 260; i++) send_byte(8'h01);
    check("err_saturate", 32'(err_count), 32'd255);

    // All-off
    do_reset();
    load4();
    send3(8'h80, 8'h43, 8'h00);
    to_update();
    check("alloff_pre_gate", 32'(voice_gate), 32'hB);
    send_byte(8'hFF);
    check("alloff_gate",   32'(voice_gate),   32'h0);
    check("alloff_change", 32'(voice_change), 32'hB);
    check("alloff_noerr",  32'(err_count),    32'h0);
    to_update();
    check("alloff_change_off", 32'(voice_change), 32'h0);
    check("alloff_led",        32'(led),          32'h0);

    // Reset during ALLOC
    do_reset();
    send3(8'h90, 8'h3C, 8'h64);
    to_update();
    send_byte(8'h40); send_byte(8'h50);
    rst_n = 1'b0;
    #1;
    check("arst_gate",  32'(voice_gate),     32'h0);
    check("arst_note",  32'(voice_note),     32'h0);
    check("arst_vel",   32'(voice_vel),      32'h0);
    check("arst_led",   32'(led),            32'h0);
    check("arst_ready", 32'(rx_if.rx_ready), 32'h1);
    @(posedge clk);
    #1;
    check("arst_change", 32'(voice_change), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    to_update();
    check("arst_post_change", 32'(voice_change), 32'h0);
    check("arst_post_gate",   32'(voice_gate),   32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
